// File: rtl/config_write_decoder.sv
// Configuration write decoder: parses header/data command bursts into
// phase-step and NoteOn config write strobes, with a sticky error flag.
`ifndef VOICE_OPERATOR_ID
`define VOICE_OPERATOR_ID 8
`endif

module config_write_decoder #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_CmdValid,
    input  logic [15:0]                   i_CmdData,
    output logic                          o_CmdReady,
    input  logic                          i_ErrorClear,
    output logic                          o_PhaseStepConfigWriteEnable,
    output logic [1:0]                    o_NoteOnConfigWriteEnable,
    output logic [`VOICE_OPERATOR_ID-1:0] o_ConfigWriteAddr,
    output logic [15:0]                   o_ConfigWriteData,
    output logic                          o_Error
);

    localparam int TimeoutWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimeoutWidth-1:0] TimeoutLast =
        TimeoutWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t                        state, stateNext;
    logic [1:0]                    sel, selNext;
    logic [`VOICE_OPERATOR_ID-1:0] addr, addrNext;
    logic [4:0]                    remaining, remainingNext;
    logic [TimeoutWidth-1:0]       timeout, timeoutNext;
    logic                          phaseNext;
    logic [1:0]                    noteNext;
    logic [`VOICE_OPERATOR_ID-1:0] writeAddrNext;
    logic [15:0]                   writeDataNext;
    logic                          errorSet, errorNext;
    logic                          accept;

    logic [3:0] hdrSel;
    logic       selNop, selPhase, selNote, selIllegal;

    assign accept     = i_CmdValid && o_CmdReady;
    assign hdrSel     = i_CmdData[15:12];
    assign selNop     = (hdrSel == 4'h0);
    assign selPhase   = (hdrSel == 4'h1);
    assign selNote    = (hdrSel[3:1] == 3'b001);
    assign selIllegal = (hdrSel[3:2] != 2'b00);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state                        <= IDLE;
            sel                          <= 2'd0;
            addr                         <= '0;
            remaining                    <= 5'd0;
            timeout                      <= '0;
            o_CmdReady                   <= 1'b0;
            o_PhaseStepConfigWriteEnable <= 1'b0;
            o_NoteOnConfigWriteEnable    <= 2'b00;
            o_ConfigWriteAddr            <= '0;
            o_ConfigWriteData            <= 16'h0000;
            o_Error                      <= 1'b0;
        end else begin
            state                        <= stateNext;
            sel                          <= selNext;
            addr                         <= addrNext;
            remaining                    <= remainingNext;
            timeout                      <= timeoutNext;
            o_CmdReady                   <= 1'b1;
            o_PhaseStepConfigWriteEnable <= phaseNext;
            o_NoteOnConfigWriteEnable    <= noteNext;
            o_ConfigWriteAddr            <= writeAddrNext;
            o_ConfigWriteData            <= writeDataNext;
            o_Error                      <= errorNext;
        end
    end

    always_comb begin
        stateNext     = state;
        selNext       = sel;
        addrNext      = addr;
        remainingNext = remaining;
        timeoutNext   = timeout;
        phaseNext     = 1'b0;
        noteNext      = 2'b00;
        writeAddrNext = o_ConfigWriteAddr;
        writeDataNext = o_ConfigWriteData;
        errorSet      = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        selNop: begin
                        end
                        selPhase: begin
                            selNext       = 2'd1;
                            addrNext      = i_CmdData[7:0];
                            remainingNext = {1'b0, i_CmdData[11:8]} + 5'd1;
                            timeoutNext   = '0;
                            stateNext     = DATA;
                        end
                        selNote: begin
                            // NoteOn halves are always a single data word
                            selNext       = hdrSel[1:0];
                            addrNext      = i_CmdData[7:0];
                            remainingNext = 5'd1;
                            timeoutNext   = '0;
                            stateNext     = DATA;
                        end
                        selIllegal: begin
                            errorSet = 1'b1;
                        end
                    endcase
                end
            end
            DATA: begin
                if (accept) begin
                    timeoutNext   = '0;
                    writeDataNext = i_CmdData;
                    writeAddrNext = addr;
                    if (sel == 2'd1) begin
                        phaseNext = 1'b1;
                        addrNext  = addr + 1'b1;
                    end else begin
                        noteNext = (sel == 2'd3) ? 2'b10 : 2'b01;
                    end
                    if (remaining == 5'd1) begin
                        stateNext = IDLE;
                    end else begin
                        remainingNext = remaining - 5'd1;
                    end
                end else if (timeout == TimeoutLast) begin
                    timeoutNext = '0;
                    errorSet    = 1'b1;
                    stateNext   = IDLE;
                end else begin
                    timeoutNext = timeout + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // A set event outranks a simultaneous clear
        errorNext = errorSet | (o_Error & ~i_ErrorClear);
    end

endmodule

// File: tb/tb_config_write_decoder.sv
// Directed self-checking bench for config_write_decoder.
// Write outputs are packed into one vector {phase, noteOn, addr, data}.
`timescale 1ns/1ps

module tb_config_write_decoder;

    localparam int TO = 1024;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_CmdValid = 1'b0;
    logic [15:0] i_CmdData = 16'h0000;
    logic        i_ErrorClear = 1'b0;
    logic        o_CmdReady;
    logic        o_PhaseStepConfigWriteEnable;
    logic [1:0]  o_NoteOnConfigWriteEnable;
    logic [7:0]  o_ConfigWriteAddr;
    logic [15:0] o_ConfigWriteData;
    logic        o_Error;

    int total = 0;
    int bad = 0;

    logic [26:0] wr;
    assign wr = {o_PhaseStepConfigWriteEnable, o_NoteOnConfigWriteEnable,
                 o_ConfigWriteAddr, o_ConfigWriteData};

    config_write_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_CmdValid(i_CmdValid),
        .i_CmdData(i_CmdData),
        .o_CmdReady(o_CmdReady),
        .i_ErrorClear(i_ErrorClear),
        .o_PhaseStepConfigWriteEnable(o_PhaseStepConfigWriteEnable),
        .o_NoteOnConfigWriteEnable(o_NoteOnConfigWriteEnable),
        .o_ConfigWriteAddr(o_ConfigWriteAddr),
        .o_ConfigWriteData(o_ConfigWriteData),
        .o_Error(o_Error)
    );

    always #5 i_Clock = ~i_Clock;

    always @(negedge i_Clock) begin
        total++;
        if ($countones({o_PhaseStepConfigWriteEnable,
                        o_NoteOnConfigWriteEnable}) > 1) begin
            bad++;
            $display("FAIL onehot got=%b%b want at most one bit",
                     o_PhaseStepConfigWriteEnable, o_NoteOnConfigWriteEnable);
        end
    end

    task automatic drive(input logic [15:0] w, input logic v);
        i_CmdValid = v;
        i_CmdData  = w;
        @(posedge i_Clock);
        #1;
    endtask

    task automatic test_reset;
        i_CmdValid = 1'b1;
        i_CmdData  = 16'h7000;
        repeat (2) @(posedge i_Clock);
        #1;
        total++;
        if ({o_CmdReady, o_Error, wr} !== 29'd0) begin
            bad++;
            $display("FAIL reset_out got=%h want=0", {o_CmdReady, o_Error, wr});
        end
        i_Reset    = 1'b0;
        i_CmdValid = 1'b0;
        #1;
        total++;
        if (o_CmdReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdy_early got=%b want=0", o_CmdReady);
        end
        @(posedge i_Clock);
        #1;
        total++;
        if (o_CmdReady !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy_rise got=%b want=1", o_CmdReady);
        end
    endtask

    task automatic test_phase_burst;
        logic [26:0] exp [4];
        logic [15:0] dat [4];
        dat = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};
        exp = '{{1'b1, 2'b00, 8'h05, 16'hAAAA},
                {1'b1, 2'b00, 8'h06, 16'hBBBB},
                {1'b1, 2'b00, 8'h07, 16'hCCCC},
                {1'b0, 2'b00, 8'h07, 16'hCCCC}};
        drive(16'h1205, 1'b1);
        total++;
        if (wr[26:24] !== 3'b000) begin
            bad++;
            $display("FAIL burst_hdr got=%b want=000", wr[26:24]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(dat[i], 1'b1);
            total++;
            if (wr !== exp[i]) begin
                bad++;
                $display("FAIL burst_w%0d got=%h want=%h", i, wr, exp[i]);
            end
        end
        drive(16'h1010, 1'b1);
        total++;
        if (wr !== exp[3]) begin
            bad++;
            $display("FAIL burst_b2b_hdr got=%h want=%h", wr, exp[3]);
        end
        drive(16'h5555, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'h10, 16'h5555}) begin
            bad++;
            $display("FAIL burst_b2b_data got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'h10, 16'h5555});
        end
        drive(16'h0000, 1'b0);
        total++;
        if (wr !== {1'b0, 2'b00, 8'h10, 16'h5555}) begin
            bad++;
            $display("FAIL burst_hold got=%h want=%h", wr,
                     {1'b0, 2'b00, 8'h10, 16'h5555});
        end
    endtask

    task automatic test_wrap;
        drive(16'h11FF, 1'b1);
        drive(16'h1111, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'hFF, 16'h1111}) begin
            bad++;
            $display("FAIL wrap_ff got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'hFF, 16'h1111});
        end
        drive(16'h2222, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'h00, 16'h2222}) begin
            bad++;
            $display("FAIL wrap_00 got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'h00, 16'h2222});
        end
        drive(16'h0000, 1'b0);
    endtask

    task automatic test_noteon;
        drive(16'h3F40, 1'b1);
        drive(16'h8000, 1'b1);
        total++;
        if ({wr[26:24], wr[15:0]} !== {3'b010, 16'h8000}) begin
            bad++;
            $display("FAIL note_hi got=%h want=%h", {wr[26:24], wr[15:0]},
                     {3'b010, 16'h8000});
        end
        drive(16'h2000, 1'b1);
        total++;
        if (wr[26:24] !== 3'b000) begin
            bad++;
            $display("FAIL note_len_ignored got=%b want=000", wr[26:24]);
        end
        drive(16'h0001, 1'b1);
        total++;
        if ({wr[26:24], wr[15:0]} !== {3'b001, 16'h0001}) begin
            bad++;
            $display("FAIL note_lo got=%h want=%h", {wr[26:24], wr[15:0]},
                     {3'b001, 16'h0001});
        end
        drive(16'h0000, 1'b0);
        total++;
        if (wr[26:24] !== 3'b000) begin
            bad++;
            $display("FAIL note_idle got=%b want=000", wr[26:24]);
        end
    endtask

    task automatic test_illegal;
        drive(16'h7000, 1'b1);
        total++;
        if ({o_Error, wr[26:24]} !== 4'b1000) begin
            bad++;
            $display("FAIL illegal_err got=%b want=1000", {o_Error, wr[26:24]});
        end
        drive(16'h1042, 1'b1);
        drive(16'h0BAD, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'h42, 16'h0BAD}) begin
            bad++;
            $display("FAIL illegal_next got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'h42, 16'h0BAD});
        end
        i_ErrorClear = 1'b1;
        drive(16'hF123, 1'b1);
        total++;
        if (o_Error !== 1'b1) begin
            bad++;
            $display("FAIL set_wins got=%b want=1", o_Error);
        end
        drive(16'h0000, 1'b0);
        i_ErrorClear = 1'b0;
        total++;
        if (o_Error !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b want=0", o_Error);
        end
    endtask

    task automatic test_timeout;
        int strobes;
        drive(16'h1300, 1'b1);
        drive(16'h1234, 1'b1);
        strobes = int'(o_PhaseStepConfigWriteEnable);
        for (int i = 0; i < TO - 1; i++) begin
            drive(16'h0000, 1'b0);
            strobes += int'(o_PhaseStepConfigWriteEnable);
        end
        total++;
        if (o_Error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got=%b want=0", o_Error);
        end
        drive(16'h0000, 1'b0);
        strobes += int'(o_PhaseStepConfigWriteEnable);
        total++;
        if (o_Error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err got=%b want=1", o_Error);
        end
        total++;
        if (strobes != 1) begin
            bad++;
            $display("FAIL timeout_strobes got=%0d want=1", strobes);
        end
        drive(16'h1050, 1'b1);
        total++;
        if (wr[26:24] !== 3'b000) begin
            bad++;
            $display("FAIL timeout_hdr got=%b want=000", wr[26:24]);
        end
        drive(16'h7777, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'h50, 16'h7777}) begin
            bad++;
            $display("FAIL timeout_next got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'h50, 16'h7777});
        end
        i_ErrorClear = 1'b1;
        drive(16'h0000, 1'b0);
        i_ErrorClear = 1'b0;
    endtask

    task automatic test_reset_midburst;
        drive(16'h1300, 1'b1);
        drive(16'h0101, 1'b1);
        drive(16'h0202, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'h01, 16'h0202}) begin
            bad++;
            $display("FAIL mid_w1 got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'h01, 16'h0202});
        end
        i_CmdData = 16'h0303;
        #2;
        i_Reset = 1'b1;
        #1;
        total++;
        if ({o_CmdReady, o_Error, wr} !== 29'd0) begin
            bad++;
            $display("FAIL mid_async got=%h want=0", {o_CmdReady, o_Error, wr});
        end
        @(posedge i_Clock);
        #1;
        total++;
        if ({o_CmdReady, o_Error, wr} !== 29'd0) begin
            bad++;
            $display("FAIL mid_held got=%h want=0", {o_CmdReady, o_Error, wr});
        end
        i_Reset    = 1'b0;
        i_CmdValid = 1'b0;
        @(posedge i_Clock);
        #1;
        total++;
        if (o_CmdReady !== 1'b1) begin
            bad++;
            $display("FAIL mid_rdy got=%b want=1", o_CmdReady);
        end
        drive(16'h0000, 1'b1);
        total++;
        if (wr !== 27'd0) begin
            bad++;
            $display("FAIL mid_nop got=%h want=0", wr);
        end
        drive(16'h1060, 1'b1);
        drive(16'h4444, 1'b1);
        total++;
        if (wr !== {1'b1, 2'b00, 8'h60, 16'h4444}) begin
            bad++;
            $display("FAIL mid_after got=%h want=%h", wr,
                     {1'b1, 2'b00, 8'h60, 16'h4444});
        end
        drive(16'h0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_phase_burst();
        test_wrap();
        test_noteon();
        test_illegal();
        test_timeout();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/config_write_decoder.md
CONFIG_WRITE_DECODER -- requirements
Module: config_write_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, the number of idle cycles allowed between words of a burst before it aborts.
REQ-002 i_Clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 i_Reset  in  1  asynchronous, active-high reset.
REQ-004 i_CmdValid  in  1  command word valid.
REQ-005 i_CmdData  in  16  command word (header or data).
REQ-006 o_CmdReady  out  1  decoder can accept a word; a word transfers on any cycle with i_CmdValid && o_CmdReady.
REQ-007 i_ErrorClear  in  1  clears o_Error.
REQ-008 o_PhaseStepConfigWriteEnable  out  1  one-cycle phase-step write strobe.
REQ-009 o_NoteOnConfigWriteEnable  out  2  [1] writes the NoteOn high half and [0] writes the low half; each is a one-cycle strobe.
REQ-010 o_ConfigWriteAddr  out  `VOICE_OPERATOR_ID (8)  voice-operator address.
REQ-011 o_ConfigWriteData  out  16  write data.
REQ-012 o_Error  out  1  sticky protocol-error flag.

Function
REQ-013 Header format: [15:12] SEL, [11:8] LEN (burst = LEN+1 words, 1..16), [7:0] ADDR.
REQ-014 SEL values: 0x0 NOP, 0x1 PhaseStep, 0x2 NoteOn low half, 0x3 NoteOn high half, 0x4-0xF illegal.
REQ-015 FSM states: IDLE and DATA; IDLE is the reset state.
REQ-016 IDLE, header with SEL 0x0 accepted: consume it, no write, stay in IDLE.
REQ-017 IDLE, header with illegal SEL accepted: consume it, set o_Error, stay in IDLE.
REQ-018 IDLE, header with SEL 0x1 accepted: latch SEL and ADDR, load remaining count = LEN+1, go to DATA.
REQ-019 IDLE, header with SEL 0x2 or 0x3 accepted: treat LEN as 0 (one data word) and ADDR as don't-care; go to DATA.
REQ-020 o_CmdReady = 1 in IDLE and DATA whenever reset is not asserted; no backpressure otherwise.
REQ-021 DATA, each accepted word: register the write outputs so the strobe rises on the next clock edge (latency 1 cycle from the accept edge), held high for exactly 1 cycle.
REQ-022 o_ConfigWriteData = accepted word; o_ConfigWriteAddr = current address.
REQ-023 SEL 0x1 strobes o_PhaseStepConfigWriteEnable; SEL 0x2 strobes o_NoteOnConfigWriteEnable = 2'b01; SEL 0x3 strobes 2'b10.
REQ-024 In a PhaseStep burst the address increments by 1 after each word, modulo 256 (0xFF wraps to 0x00).
REQ-025 Remaining count decrements on each accepted data word; when the last word is accepted, return to IDLE the same edge.
REQ-026 Back-to-back accepted words produce strobes on consecutive cycles; a header may follow the last data word with no gap.
REQ-027 When no write occurs, all enables = 0, and o_ConfigWriteAddr / o_ConfigWriteData hold their last values.
REQ-028 Timeout counter clears on entry to DATA and on each accepted word, and increments on each DATA cycle with no accept.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES: go to IDLE, set o_Error, issue no strobe; words already written remain written.
REQ-030 i_ErrorClear clears o_Error on the next edge.
REQ-031 If an error-set event and i_ErrorClear occur in the same cycle, o_Error = 1 (set wins).
REQ-032 At most one enable bit across all write-enable outputs is high in any cycle.

Reset
REQ-033 While i_Reset = 1, all outputs are forced to 0 immediately (asynchronously): o_CmdReady, all enables, o_ConfigWriteAddr, o_ConfigWriteData, o_Error.
REQ-034 While i_Reset = 1, the FSM is forced to IDLE and the counters are cleared.
REQ-035 Reset asserted mid-burst aborts the burst; no strobe is issued for any word not already accepted, including a strobe pending from the reset cycle.
REQ-036 o_CmdReady rises on the first clock edge after i_Reset deasserts.

Verification
REQ-037 Header 0x1205, then data 0xAAAA, 0xBBBB, 0xCCCC back-to-back -> PhaseStep strobes on 3 consecutive cycles, addr 0x05/0x06/0x07, data in order, then IDLE.
REQ-038 Header 0x11FF, then data 0x1111, 0x2222 -> writes to addr 0xFF then 0x00 (wrap).
REQ-039 Header 0x3F40, then data 0x8000; header 0x2000, then data 0x0001 -> NoteOn enable 2'b10 with 0x8000, then 2'b01 with 0x0001; LEN ignored, one word each.
REQ-040 Header 0x7000 -> o_Error = 1, no strobe, next header accepted normally; i_ErrorClear pulsed together with another illegal header -> o_Error stays 1.
REQ-041 Header 0x1300, one data word, then i_CmdValid low for TIMEOUT_CYCLES cycles -> exactly one strobe, o_Error = 1, FSM back in IDLE; the next word is decoded as a header.
REQ-042 i_Reset asserted after the 2nd of 4 burst words -> outputs 0 immediately, no further strobes, and after release header 0x0000 is consumed as a NOP.
